// File: rtl/rr_arb8.sv
// Eight-way round-robin arbiter with a hold-time limit.
// A grant is registered one cycle after arbitration, and every release is followed by one idle bubble cycle.
module rr_arb8 #(
    parameter int unsigned HOLD_MAX = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    // Handshake: in IDLE a nonzero req is granted at the next edge. The holder
    // keeps the grant until it pulses done, drops its req bit, or hits HOLD_MAX.
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t     state, state_nxt;
    logic [2:0] ptr, ptr_nxt;
    logic [2:0] idx_q, idx_nxt;
    logic [7:0] gnt_q, gnt_nxt;
    logic [7:0] hold_cnt, hold_nxt;
    logic       to_q, to_nxt;

    logic [2:0] cand;
    logic [2:0] pick_idx;
    logic       pick_found;
    logic       hold_hit;
    logic       rel_user;

    // First requester at or after ptr, wrapping 7 -> 0.
    always_comb begin
        cand       = '0;
        pick_idx   = ptr;
        pick_found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cand = ptr + 3'(i);
            if (!pick_found && req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    assign hold_hit = (hold_cnt == 8'(HOLD_MAX));
    assign rel_user = done || !req[idx_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= '0;
            idx_q    <= '0;
            gnt_q    <= '0;
            hold_cnt <= '0;
            to_q     <= 1'b0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            idx_q    <= idx_nxt;
            gnt_q    <= gnt_nxt;
            hold_cnt <= hold_nxt;
            to_q     <= to_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        idx_nxt   = idx_q;
        gnt_nxt   = gnt_q;
        hold_nxt  = hold_cnt;
        to_nxt    = 1'b0;
        case (state)
            IDLE: begin
                hold_nxt = '0;
                if (pick_found) begin
                    state_nxt = BUSY;
                    gnt_nxt   = 8'b1 << pick_idx;
                    idx_nxt   = pick_idx;
                    hold_nxt  = 8'd1;
                end
            end
            BUSY: begin
                if (rel_user || hold_hit) begin
                    state_nxt = IDLE;
                    gnt_nxt   = '0;
                    hold_nxt  = '0;
                    ptr_nxt   = idx_q + 3'd1;
                    // A coincident done or request drop counts as a normal release.
                    to_nxt    = hold_hit && !rel_user;
                end else begin
                    hold_nxt = hold_cnt + 8'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
                hold_nxt  = '0;
            end
        endcase
    end

    always_comb begin
        gnt       = gnt_q;
        gnt_idx   = idx_q;
        gnt_valid = (state == BUSY);
        timeout   = to_q;
    end

endmodule

// File: tb/tb_rr_arb8.sv
// Directed bench for rr_arb8: reset, fairness, wrap, timeout, coincident release, async reset.
// A second instance built with HOLD_MAX=1 covers single-cycle grants.
module tb_rr_arb8;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt,  gnt1;
    logic [2:0] gnt_idx, gnt_idx1;
    logic       gnt_valid, gnt_valid1;
    logic       timeout, timeout1;

    int n_vec = 0;
    int n_err = 0;

    rr_arb8 #(.HOLD_MAX(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done),
        .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid), .timeout(timeout)
    );

    rr_arb8 #(.HOLD_MAX(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done),
        .gnt(gnt1), .gnt_idx(gnt_idx1), .gnt_valid(gnt_valid1), .timeout(timeout1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic chk_grant(input string tag, input logic [7:0] g, input logic [2:0] idx);
        chk({tag, "_gnt"}, 32'(gnt), 32'(g));
        chk({tag, "_idx"}, 32'(gnt_idx), 32'(idx));
        chk({tag, "_valid"}, 32'(gnt_valid), 32'd1);
    endtask

    task automatic chk_idle(input string tag, input logic to_exp);
        chk({tag, "_gnt0"}, 32'(gnt), 32'h0);
        chk({tag, "_valid0"}, 32'(gnt_valid), 32'd0);
        chk({tag, "_to"}, 32'(timeout), 32'(to_exp));
    endtask

    initial begin
        rst_n = 1'b1;
        req   = 8'h00;
        done  = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_idx", 32'(gnt_idx), 32'h0);
        chk("rst_valid", 32'(gnt_valid), 32'h0);
        chk("rst_to", 32'(timeout), 32'h0);
        chk("rst_gnt1", 32'(gnt1), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Basic grant and done release; ptr should move to 1.
        req = 8'h01;
        step(); chk_grant("basic", 8'h01, 3'd0);
        done = 1'b1;
        step(); chk_idle("basic_rel", 1'b0);
        done = 1'b0;
        req = 8'h03;
        step(); chk_grant("ptr1", 8'h02, 3'd1);
        done = 1'b1;
        step(); chk_idle("ptr1_rel", 1'b0);
        done = 1'b0;
        req = 8'h00;

        // Fairness: all requesting, done held high, order 0..7,0 with bubbles.
        do_reset();
        req  = 8'hFF;
        done = 1'b1;
        for (int k = 0; k < 9; k++) begin
            step(); chk_grant($sformatf("fair%0d", k), 8'h01 << (k % 8), 3'(k % 8));
            chk($sformatf("fair%0d_to", k), 32'(timeout), 32'd0);
            step(); chk_idle($sformatf("fair%0d_bub", k), 1'b0);
        end
        done = 1'b0;
        req  = 8'h00;

        // Wrap: drive ptr to 6 via D5, then req 8'h21 must go to D0, then D5.
        req = 8'h20;
        step(); chk_grant("wrap_d5a", 8'h20, 3'd5);
        done = 1'b1;
        step(); chk_idle("wrap_rel_a", 1'b0);
        done = 1'b0;
        req = 8'h21;
        step(); chk_grant("wrap_d0", 8'h01, 3'd0);
        done = 1'b1;
        step(); chk_idle("wrap_rel_b", 1'b0);
        done = 1'b0;
        step(); chk_grant("wrap_d5b", 8'h20, 3'd5);
        done = 1'b1;
        step(); chk_idle("wrap_rel_c", 1'b0);
        done = 1'b0;
        req = 8'h00;

        // Timeout: D4 held with no done for exactly 8 cycles.
        req = 8'h10;
        for (int i = 1; i <= 8; i++) begin
            if (i > 1) step();
            else step();
            chk_grant($sformatf("hold%0d", i), 8'h10, 3'd4);
            chk($sformatf("hold%0d_to", i), 32'(timeout), 32'd0);
        end
        step(); chk_idle("tmo", 1'b1);
        step(); chk_grant("regrant", 8'h10, 3'd4);
        chk("regrant_to", 32'(timeout), 32'd0);

        // Other request bits toggle while busy; done lands on the 8th cycle.
        req = 8'hFF;
        for (int i = 2; i <= 8; i++) begin
            step(); chk_grant($sformatf("oth%0d", i), 8'h10, 3'd4);
        end
        done = 1'b1;
        step(); chk_idle("coinc", 1'b0);
        done = 1'b0;
        req = 8'h10;
        step(); chk_grant("drop_g", 8'h10, 3'd4);
        req = 8'h00;
        step(); chk_idle("drop_rel", 1'b0);

        // Async reset mid-grant, then search restarts from ptr 0.
        req = 8'h08;
        step(); chk_grant("ar_g", 8'h08, 3'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_gnt", 32'(gnt), 32'h0);
        chk("ar_valid", 32'(gnt_valid), 32'h0);
        chk("ar_idx", 32'(gnt_idx), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        req = 8'h88;
        step(); chk_grant("ar_ptr0", 8'h08, 3'd3);
        done = 1'b1;
        step(); chk_idle("ar_rel", 1'b0);
        done = 1'b0;
        req = 8'h00;

        // HOLD_MAX=1 instance: one-cycle grant, timeout, regrant.
        do_reset();
        req = 8'h04;
        step();
        chk("h1_gnt", 32'(gnt1), 32'h04);
        chk("h1_valid", 32'(gnt_valid1), 32'd1);
        chk("h1_idx", 32'(gnt_idx1), 32'd2);
        step();
        chk("h1_rel_valid", 32'(gnt_valid1), 32'd0);
        chk("h1_rel_to", 32'(timeout1), 32'd1);
        chk("h1_rel_gnt", 32'(gnt1), 32'h0);
        step();
        chk("h1_regrant", 32'(gnt1), 32'h04);
        chk("h1_regrant_to", 32'(timeout1), 32'd0);
        req = 8'h00;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
